// File: rtl/id_pkg.sv
// Shared defaults and helpers for the ID-stage register file and load-use scoreboard.
package id_pkg;

  localparam int unsigned XlenDef = 32;
  localparam int unsigned NregDef = 32;
  localparam int unsigned AwDef   = 5;
  localparam int unsigned X0Addr  = 0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_scoreboard_regfile_if.sv
// ID-stage operand/writeback/issue bundle between the pipeline and the scoreboarded register file.
interface id_scoreboard_regfile_if
  import id_pkg::*;
#(
  parameter int unsigned XLEN = XlenDef,
  parameter int unsigned AW   = AwDef,
  parameter int unsigned NRD  = 2
);
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD-1:0]      rs_used;
  logic [NRD*XLEN-1:0] rs_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_is_load;
  logic                flush;
  logic                stall;
  logic                if_write;
  logic [31:0]         stall_count;

  modport master (
    output rs_addr, rs_used, wr_en, wr_addr, wr_data, iss_valid, iss_rd, iss_is_load, flush,
    input  rs_data, stall, if_write, stall_count
  );

  modport slave (
    input  rs_addr, rs_used, wr_en, wr_addr, wr_data, iss_valid, iss_rd, iss_is_load, flush,
    output rs_data, stall, if_write, stall_count
  );
endinterface

// File: rtl/id_regfile.sv
// Architectural register file: x0 and out-of-range reads return 0, optional write-through bypass.
module id_regfile
  import id_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDef,
  parameter int unsigned NREG   = NregDef,
  parameter int unsigned AW     = AwDef,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_ok;

  assign wr_ok = wr_en_i && (32'(wr_addr_i) != X0Addr) && (32'(wr_addr_i) < NREG);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          valid_addr;
    logic          fwd;
    assign addr       = rd_addr_i[i*AW +: AW];
    assign valid_addr = (32'(addr) != X0Addr) && (32'(addr) < NREG);
    assign fwd        = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr);
    assign rd_data_o[i*XLEN +: XLEN] = !valid_addr ? '0 :
                                       fwd         ? wr_data_i : regs_q[addr];
  end

endmodule

// File: rtl/id_scoreboard_regfile.sv
// ID-stage register file with per-register load-latency scoreboard, stall and stall counter.
module id_scoreboard_regfile
  import id_pkg::*;
#(
  parameter int unsigned XLEN     = XlenDef,
  parameter int unsigned NREG     = NregDef,
  parameter int unsigned AW       = AwDef,
  parameter int unsigned NRD      = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  id_scoreboard_regfile_if.slave bus
);

  localparam int unsigned CW = clog2(LOAD_LAT + 1);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [NRD-1:0] src_hit;
  logic           stall;
  logic           iss_ok;
  logic [31:0]    stall_count_q;

  id_regfile #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .AW    (AW),
    .NRD   (NRD),
    .BYPASS(BYPASS)
  ) u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .wr_en_i  (bus.wr_en),
    .wr_addr_i(bus.wr_addr),
    .wr_data_i(bus.wr_data),
    .rd_addr_i(bus.rs_addr),
    .rd_data_o(bus.rs_data)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_src
    logic [AW-1:0] addr;
    assign addr       = bus.rs_addr[i*AW +: AW];
    assign src_hit[i] = bus.rs_used[i] && (32'(addr) != X0Addr) && (32'(addr) < NREG) &&
                        (cnt_q[addr] != '0);
  end

  assign stall  = |src_hit;
  // A flushed or stalled instruction never claims its destination.
  assign iss_ok = bus.iss_valid && !stall && !bus.flush &&
                  (32'(bus.iss_rd) != X0Addr) && (32'(bus.iss_rd) < NREG);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : cnt_q[r];
    end
    if (iss_ok) begin
      cnt_d[bus.iss_rd] = bus.iss_is_load ? CW'(LOAD_LAT) : '0;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.if_write    = ~stall;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_id_scoreboard_regfile.sv
// Two DUT configurations share one stimulus stream; a reference model queues expectations.
module tb_id_scoreboard_regfile;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NREG = 24;
  localparam int unsigned LL_A = 1;
  localparam int unsigned LL_B = 3;

  typedef struct packed {
    logic          rst_n;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    used;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_is_load;
    logic          flush;
  } stim_t;

  typedef struct packed {
    logic [63:0] rd;
    logic        stall;
    logic [31:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_scoreboard_regfile_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) if_a ();
  id_scoreboard_regfile_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) if_b ();

  id_scoreboard_regfile #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .LOAD_LAT(LL_A), .BYPASS(1)
  ) u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_a)
  );

  id_scoreboard_regfile #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .LOAD_LAT(LL_B), .BYPASS(0)
  ) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_b)
  );

  int total = 0;
  int bad   = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic [31:0] m_reg [NREG];
  int          m_cnt [2][NREG];
  logic [31:0] m_sc  [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model_out(input int k, input stim_t s);
    exp_t e;
    int   a;
    e.rd    = '0;
    e.stall = 1'b0;
    e.sc    = m_sc[k];
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? int'(s.a0) : int'(s.a1);
      if (a != 0 && a < int'(NREG)) begin
        if (k == 0 && s.wr_en && int'(s.wr_addr) == a) e.rd[i*32 +: 32] = s.wr_data;
        else e.rd[i*32 +: 32] = m_reg[a];
        if (s.used[i] && m_cnt[k][a] > 0) e.stall = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_step(input stim_t s, input logic st_a, input logic st_b);
    logic st;
    if (!s.rst_n) begin
      for (int r = 0; r < int'(NREG); r++) begin
        m_reg[r] = '0;
        m_cnt[0][r] = 0;
        m_cnt[1][r] = 0;
      end
      m_sc[0] = '0;
      m_sc[1] = '0;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      st = (k == 0) ? st_a : st_b;
      if (st && m_sc[k] != 32'hFFFF_FFFF) m_sc[k] = m_sc[k] + 1;
      for (int r = 0; r < int'(NREG); r++) if (m_cnt[k][r] > 0) m_cnt[k][r]--;
      if (s.iss_valid && !st && !s.flush && s.iss_rd != 0 && int'(s.iss_rd) < int'(NREG))
        m_cnt[k][s.iss_rd] = s.iss_is_load ? ((k == 0) ? int'(LL_A) : int'(LL_B)) : 0;
    end
    if (s.wr_en && s.wr_addr != 0 && int'(s.wr_addr) < int'(NREG)) m_reg[s.wr_addr] = s.wr_data;
  endtask

  task automatic drive_if(input stim_t s);
    if_a.rs_addr = {s.a1, s.a0};     if_b.rs_addr = {s.a1, s.a0};
    if_a.rs_used = s.used;           if_b.rs_used = s.used;
    if_a.wr_en = s.wr_en;            if_b.wr_en = s.wr_en;
    if_a.wr_addr = s.wr_addr;        if_b.wr_addr = s.wr_addr;
    if_a.wr_data = s.wr_data;        if_b.wr_data = s.wr_data;
    if_a.iss_valid = s.iss_valid;    if_b.iss_valid = s.iss_valid;
    if_a.iss_rd = s.iss_rd;          if_b.iss_rd = s.iss_rd;
    if_a.iss_is_load = s.iss_is_load; if_b.iss_is_load = s.iss_is_load;
    if_a.flush = s.flush;            if_b.flush = s.flush;
  endtask

  task automatic step(input stim_t s);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    drive_if(s);
    rst_n = s.rst_n;
    ea = '0;
    eb = '0;
    if (s.rst_n) begin
      ea = model_out(0, s);
      eb = model_out(1, s);
      qa.push_back(ea);
      qb.push_back(eb);
    end
    model_step(s, ea.stall, eb.stall);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t ins(input int rs0, input int u0, input int rd, input int ld,
                                input int fl);
    stim_t s;
    s = idle();
    s.a0 = AW'(rs0);
    s.used = {1'b0, u0[0]};
    s.iss_valid = 1'b1;
    s.iss_rd = AW'(rd);
    s.iss_is_load = ld[0];
    s.flush = fl[0];
    return s;
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_rs_data", if_a.rs_data, e.rd);
      chk("a_stall", 64'(if_a.stall), 64'(e.stall));
      chk("a_if_write", 64'(if_a.if_write), 64'(!e.stall));
      chk("a_stall_count", 64'(if_a.stall_count), 64'(e.sc));
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_rs_data", if_b.rs_data, e.rd);
      chk("b_stall", 64'(if_b.stall), 64'(e.stall));
      chk("b_if_write", 64'(if_b.if_write), 64'(!e.stall));
      chk("b_stall_count", 64'(if_b.stall_count), 64'(e.sc));
    end
  end

  initial begin : driver
    stim_t s;
    drive_if('0);
    s = '0;
    step(s);
    step(s);
    // Register write/read, x0 write, bypass, out-of-range.
    s = idle(); s.wr_en = 1; s.wr_addr = 5; s.wr_data = 32'hDEADBEEF; s.a0 = 5; step(s);
    s = idle(); s.a0 = 5; s.wr_en = 1; s.wr_addr = 0; s.wr_data = 32'h1234; step(s);
    s = idle(); s.a0 = 0; s.a1 = 5; step(s);
    s = idle(); s.wr_en = 1; s.wr_addr = 7; s.wr_data = 32'hA5A5A5A5; s.a1 = 7; step(s);
    s = idle(); s.a1 = 7; step(s);
    s = idle(); s.wr_en = 1; s.wr_addr = 30; s.wr_data = 32'h5555AAAA; s.a0 = 30; s.a1 = 30;
    step(s);
    s = idle(); s.a0 = 30; s.used = 2'b11; step(s);
    // Back-to-back load-use, unused source and x0 source.
    step(ins(0, 0, 3, 1, 0));
    for (int i = 0; i < 4; i++) step(ins(3, 1, 10, 0, 0));
    step(ins(0, 0, 3, 1, 0));
    for (int i = 0; i < 3; i++) step(ins(3, 0, 11, 0, 0));
    step(ins(0, 0, 3, 1, 0));
    step(ins(0, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) step(idle());
    // Load, independent, user.
    step(ins(0, 0, 9, 1, 0));
    step(ins(1, 1, 12, 0, 0));
    for (int i = 0; i < 4; i++) step(ins(9, 1, 13, 0, 0));
    // Load then ALU overwrite; flushed load.
    step(ins(0, 0, 4, 1, 0));
    step(ins(0, 0, 4, 0, 0));
    for (int i = 0; i < 3; i++) step(ins(4, 1, 14, 0, 0));
    step(ins(0, 0, 6, 1, 1));
    for (int i = 0; i < 3; i++) step(ins(6, 1, 15, 0, 0));
    // Reset while stalled.
    step(ins(0, 0, 8, 1, 0));
    step(ins(8, 1, 16, 0, 0));
    s = ins(8, 1, 16, 0, 0); s.rst_n = 0; step(s);
    for (int i = 0; i < 2; i++) step(ins(8, 1, 16, 0, 0));
    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.a0 = AW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      s.a1 = AW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      s.used = 2'($urandom_range(0, 3));
      s.wr_en = 1'($urandom_range(0, 1));
      s.wr_addr = AW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      s.wr_data = $urandom;
      s.iss_valid = ($urandom_range(0, 3) != 0);
      s.iss_rd = AW'($urandom_range(0, 7));
      s.iss_is_load = 1'($urandom_range(0, 1));
      s.flush = ($urandom_range(0, 7) == 0);
      step(s);
    end
    repeat (3) @(negedge clk);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
